// File: rtl/puf_pkg.sv
// Shared definitions for the RO-PUF challenge/response path.
// Contents: default challenge/response widths (shared with the PUF top),
// the sweep FSM state type, and the majority-vote threshold helper.
package puf_pkg;

  localparam int unsigned PUF_CHAL_W = 5;
  localparam int unsigned PUF_RESP_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_EMIT   = 2'd3
  } sweep_state_t;

  // A bit votes 1 when its ones count strictly exceeds this value.
  function automatic int unsigned majority_threshold(input int unsigned repeats);
    return repeats / 2;
  endfunction

endpackage

// File: rtl/puf_majority_vote.sv
// Per-bit majority voter over repeated PUF response samples.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   clear_i     - zero all ones-counters
//   accum_i     - add sample_i into the ones-counters this cycle
//   sample_i    - raw response sample
//   result_o    - combinational vote that already includes the current
//                 sample_i, so the final sample can be voted on its own edge
module puf_majority_vote
  import puf_pkg::*;
#(
  parameter int unsigned RESP_W  = PUF_RESP_W,
  parameter int unsigned REPEATS = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              accum_i,
  input  logic [RESP_W-1:0] sample_i,
  output logic [RESP_W-1:0] result_o
);

  localparam int unsigned CNT_W  = $clog2(REPEATS + 1);
  localparam int unsigned SUM_W  = CNT_W + 1;
  localparam int unsigned THRESH = majority_threshold(REPEATS);

  for (genvar i = 0; i < int'(RESP_W); i++) begin : g_lane
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Ones counter for lane i.
    always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
        cnt_d = '0;
      end else if (accum_i) begin
        cnt_d = cnt_q + CNT_W'(sample_i[i]);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign result_o[i] = (SUM_W'(cnt_q) + SUM_W'(sample_i[i])) > SUM_W'(THRESH);
  end

endmodule

// File: rtl/puf_sweep_controller.sv
// RO-PUF sweep initiator: walks an inclusive (possibly wrapping) challenge
// range, settles the PUF on each challenge, majority-votes REPEATS samples
// and streams one response word per challenge over valid/ready.
// Ports:
//   clk, rst_n              - clock, async active-low reset
//   start, abort            - sweep request (idle only) / synchronous abort
//   first_chal, last_chal   - sweep range, latched on accepted start
//   challenge, puf_en       - drive to PUF core
//   puf_resp                - raw PUF response
//   resp_valid/ready/data/chal - voted response stream
//   busy                    - combinational, high when not idle
//   done                    - one-cycle pulse after the final handshake
module puf_sweep_controller
  import puf_pkg::*;
#(
  parameter int unsigned CHAL_W        = PUF_CHAL_W,
  parameter int unsigned RESP_W        = PUF_RESP_W,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned REPEATS       = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CHAL_W-1:0] first_chal,
  input  logic [CHAL_W-1:0] last_chal,
  output logic [CHAL_W-1:0] challenge,
  output logic              puf_en,
  input  logic [RESP_W-1:0] puf_resp,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [RESP_W-1:0] resp_data,
  output logic [CHAL_W-1:0] resp_chal,
  output logic              busy,
  output logic              done
);

  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned SMP_W = $clog2(REPEATS + 1);

  sweep_state_t      state_q, state_d;
  logic [CHAL_W-1:0] cur_q, cur_d;
  logic [CHAL_W-1:0] last_q, last_d;
  logic [SET_W-1:0]  set_cnt_q, set_cnt_d;
  logic [SMP_W-1:0]  smp_cnt_q, smp_cnt_d;
  logic [CHAL_W-1:0] challenge_q, challenge_d;
  logic              puf_en_q, puf_en_d;
  logic              resp_valid_q, resp_valid_d;
  logic [RESP_W-1:0] resp_data_q, resp_data_d;
  logic [CHAL_W-1:0] resp_chal_q, resp_chal_d;
  logic              done_q, done_d;
  logic              mv_clear, mv_accum;
  logic [RESP_W-1:0] mv_result;

  puf_majority_vote #(
    .RESP_W  (RESP_W),
    .REPEATS (REPEATS)
  ) u_vote (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (mv_clear),
    .accum_i  (mv_accum),
    .sample_i (puf_resp),
    .result_o (mv_result)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    last_d      = last_q;
    set_cnt_d   = set_cnt_q;
    smp_cnt_d   = smp_cnt_q;
    resp_data_d = resp_data_q;
    resp_chal_d = resp_chal_q;
    done_d      = 1'b0;
    mv_clear    = 1'b0;
    mv_accum    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          last_d    = last_chal;
          cur_d     = first_chal;
          set_cnt_d = '0;
          mv_clear  = 1'b1;
          state_d   = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (set_cnt_q == SET_W'(SETTLE_CYCLES - 1)) begin
          smp_cnt_d = '0;
          state_d   = ST_SAMPLE;
        end else begin
          set_cnt_d = set_cnt_q + SET_W'(1);
        end
      end
      ST_SAMPLE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          mv_accum = 1'b1;
          if (smp_cnt_q == SMP_W'(REPEATS - 1)) begin
            resp_data_d = mv_result;
            resp_chal_d = cur_q;
            state_d     = ST_EMIT;
          end else begin
            smp_cnt_d = smp_cnt_q + SMP_W'(1);
          end
        end
      end
      ST_EMIT: begin
        // An abort alongside a handshake still lets the word go out; it only
        // suppresses done and the advance.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (resp_ready) begin
          if (cur_q == last_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cur_d     = cur_q + CHAL_W'(1);
            set_cnt_d = '0;
            mv_clear  = 1'b1;
            state_d   = ST_SETTLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    puf_en_d     = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
    resp_valid_d = (state_d == ST_EMIT);
    // challenge holds its last value outside SETTLE.
    challenge_d  = (state_d == ST_SETTLE) ? cur_d : challenge_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cur_q        <= '0;
      last_q       <= '0;
      set_cnt_q    <= '0;
      smp_cnt_q    <= '0;
      challenge_q  <= '0;
      puf_en_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_chal_q  <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      last_q       <= last_d;
      set_cnt_q    <= set_cnt_d;
      smp_cnt_q    <= smp_cnt_d;
      challenge_q  <= challenge_d;
      puf_en_q     <= puf_en_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_chal_q  <= resp_chal_d;
      done_q       <= done_d;
    end
  end

  assign challenge  = challenge_q;
  assign puf_en     = puf_en_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_chal  = resp_chal_q;
  assign done       = done_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_puf_sweep_controller.sv
// Self-checking bench for puf_sweep_controller: randomized sweeps compared
// against a transaction-level reference model of the sweep rules.
module tb_puf_sweep_controller;

  localparam int CHAL_W        = 5;
  localparam int RESP_W        = 8;
  localparam int SETTLE_CYCLES = 16;
  localparam int REPEATS       = 3;
  localparam int NCHAL         = 1 << CHAL_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [CHAL_W-1:0] first_chal = '0;
  logic [CHAL_W-1:0] last_chal = '0;
  logic [CHAL_W-1:0] challenge;
  logic              puf_en;
  logic [RESP_W-1:0] puf_resp = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [RESP_W-1:0] resp_data;
  logic [CHAL_W-1:0] resp_chal;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  puf_sweep_controller #(
    .CHAL_W        (CHAL_W),
    .RESP_W        (RESP_W),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .REPEATS       (REPEATS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .first_chal (first_chal),
    .last_chal  (last_chal),
    .challenge  (challenge),
    .puf_en     (puf_en),
    .puf_resp   (puf_resp),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_chal  (resp_chal),
    .busy       (busy),
    .done       (done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state (transaction level).
  bit                m_active, m_valid, m_done;
  int                m_wait;   // edges left until the voted word appears
  int                m_idx;    // challenges completed in the current sweep
  logic [CHAL_W-1:0] m_chals[$];
  logic [CHAL_W-1:0] m_challenge, m_chal;
  logic [RESP_W-1:0] m_data;
  logic [RESP_W-1:0] m_samples[$];

  // Observed DUT activity.
  int                dut_hs = 0;
  int                dut_done = 0;
  logic [CHAL_W-1:0] dut_chals[$];
  bit                hs_pend;
  logic [CHAL_W-1:0] chal_pend;

  // Stimulus knobs.
  int                ready_mode = 0;  // 0 always, 1 random, 2 stall 10, 3 never
  int                resp_mode = 0;   // 0 constant, 1 random, 2 pattern
  int                abort_mode = 0;  // 0 none, 1 in 2nd challenge's sampling, 2 random
  int                stall_cnt = 0;
  logic [RESP_W-1:0] const_resp = 8'hA5;
  logic [RESP_W-1:0] pat[REPEATS];

  function automatic logic [RESP_W-1:0] vote();
    logic [RESP_W-1:0] r;
    int ones;
    for (int b = 0; b < RESP_W; b++) begin
      ones = 0;
      foreach (m_samples[k]) ones += int'(m_samples[k][b]);
      r[b] = (ones * 2 > REPEATS);
    end
    return r;
  endfunction

  function automatic void model_reset();
    m_active = 0; m_valid = 0; m_done = 0; m_wait = 0; m_idx = 0;
    m_chals.delete(); m_samples.delete();
    m_challenge = '0; m_chal = '0; m_data = '0;
  endfunction

  function automatic void model_edge();
    int span;
    m_done = 0;
    if (!m_active) begin
      if (start && !abort) begin
        span = (int'(last_chal) - int'(first_chal) + NCHAL) % NCHAL;
        m_chals.delete();
        for (int k = 0; k <= span; k++) m_chals.push_back(CHAL_W'(int'(first_chal) + k));
        m_active = 1; m_valid = 0; m_idx = 0;
        m_wait = SETTLE_CYCLES + REPEATS;
        m_challenge = m_chals[0];
        m_samples.delete();
      end
    end else if (abort) begin
      m_active = 0; m_valid = 0;
    end else if (m_valid) begin
      if (resp_ready) begin
        void'(m_chals.pop_front());
        m_valid = 0;
        if (m_chals.size() == 0) begin
          m_active = 0; m_done = 1;
        end else begin
          m_idx++;
          m_wait = SETTLE_CYCLES + REPEATS;
          m_challenge = m_chals[0];
          m_samples.delete();
        end
      end
    end else begin
      if (m_wait <= REPEATS) m_samples.push_back(puf_resp);
      m_wait--;
      if (m_wait == 0) begin
        m_valid = 1; m_data = vote(); m_chal = m_chals[0];
      end
    end
  endfunction

  task automatic check_outputs();
    if (done) dut_done++;
    check("busy", 32'(busy), 32'(m_active));
    check("puf_en", 32'(puf_en), 32'(m_active && !m_valid));
    check("resp_valid", 32'(resp_valid), 32'(m_valid));
    check("done", 32'(done), 32'(m_done));
    check("challenge", 32'(challenge), 32'(m_challenge));
    check("resp_data", 32'(resp_data), 32'(m_data));
    if (m_valid) check("resp_chal", 32'(resp_chal), 32'(m_chal));
  endtask

  // Advance one clock: model and DUT see the same inputs at the edge.
  task automatic step();
    hs_pend   = resp_valid && resp_ready;
    chal_pend = resp_chal;
    @(posedge clk);
    if (rst_n) model_edge(); else model_reset();
    #1;
    if (hs_pend) begin
      dut_hs++;
      dut_chals.push_back(chal_pend);
    end
    check_outputs();
  endtask

  task automatic drive();
    case (ready_mode)
      0: resp_ready = 1'b1;
      1: resp_ready = 1'($urandom_range(0, 1));
      2: begin
        if (m_valid) begin
          resp_ready = (stall_cnt >= 10);
          stall_cnt++;
        end else begin
          resp_ready = 1'b0;
          stall_cnt = 0;
        end
      end
      default: resp_ready = 1'b0;
    endcase
    if (resp_mode == 0) puf_resp = const_resp;
    else if (resp_mode == 2 && m_active && !m_valid && m_wait <= REPEATS && m_wait >= 1)
      puf_resp = pat[REPEATS - m_wait];
    else puf_resp = RESP_W'($urandom);
    abort = 1'b0;
    if (abort_mode == 1 && m_active && !m_valid && m_idx == 1 && m_wait == 2) begin
      abort = 1'b1;
      abort_mode = 0;
    end else if (abort_mode == 2 && m_active && $urandom_range(0, 63) == 0) begin
      abort = 1'b1;
    end
    // Starts while busy must be ignored, range inputs included.
    start = 1'b0;
    if (m_active && !m_valid && $urandom_range(0, 15) == 0) begin
      start = 1'b1;
      first_chal = CHAL_W'($urandom);
      last_chal = CHAL_W'($urandom);
    end
  endtask

  task automatic run_sweep(input logic [CHAL_W-1:0] f, input logic [CHAL_W-1:0] l);
    int n = 0;
    drive();
    start = 1'b1; abort = 1'b0; first_chal = f; last_chal = l;
    step();
    while (m_active && n < 3000) begin
      drive();
      step();
      n++;
    end
    check("sweep_bound", 32'(n < 3000), 32'd1);
  endtask

  int                hs0, dn0, n;
  logic [CHAL_W-1:0] wexp[4];
  logic [CHAL_W-1:0] f;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;

    // Single challenge, constant response: 19-cycle latency, done after handshake.
    ready_mode = 0; resp_mode = 0; const_resp = 8'hA5;
    dn0 = dut_done; hs0 = dut_hs;
    run_sweep(5'd3, 5'd3);
    step();
    check("single_hs", 32'(dut_hs - hs0), 32'd1);
    check("single_done", 32'(dut_done - dn0), 32'd1);

    // Start with simultaneous abort is refused.
    drive();
    start = 1'b1; abort = 1'b1; first_chal = 5'd7; last_chal = 5'd9;
    step();
    check("start_abort_busy", 32'(busy), 32'd0);

    // Majority vote patterns.
    resp_mode = 2;
    pat[0] = 8'hFF; pat[1] = 8'h0F; pat[2] = 8'hF0;
    run_sweep(5'd5, 5'd5);
    check("vote_ff", 32'(resp_data), 32'hFF);
    pat[0] = 8'h01; pat[1] = 8'h00; pat[2] = 8'h01;
    run_sweep(5'd6, 5'd6);
    check("vote_01", 32'(resp_data), 32'h01);

    // Wrapping sweep 30,31,0,1.
    resp_mode = 1;
    dut_chals.delete(); hs0 = dut_hs; dn0 = dut_done;
    run_sweep(5'd30, 5'd1);
    step();
    wexp[0] = 5'd30; wexp[1] = 5'd31; wexp[2] = 5'd0; wexp[3] = 5'd1;
    check("wrap_hs", 32'(dut_hs - hs0), 32'd4);
    check("wrap_done", 32'(dut_done - dn0), 32'd1);
    for (int k = 0; k < 4; k++) begin
      if (k < dut_chals.size()) check("wrap_chal", 32'(dut_chals[k]), 32'(wexp[k]));
    end

    // Back-pressure: ready low 10 cycles in each EMIT.
    ready_mode = 2;
    run_sweep(5'd10, 5'd11);

    // Abort while sampling the second challenge, then restart fresh.
    ready_mode = 0; abort_mode = 1; dn0 = dut_done;
    run_sweep(5'd12, 5'd15);
    step();
    check("abort_no_done", 32'(dut_done - dn0), 32'd0);
    check("abort_idle", 32'(busy), 32'd0);
    abort_mode = 0;
    run_sweep(5'd20, 5'd21);

    // Reset asserted while a response is waiting in EMIT.
    ready_mode = 3; dn0 = dut_done; n = 0;
    drive();
    start = 1'b1; first_chal = 5'd8; last_chal = 5'd9;
    step();
    while (!m_valid && n < 100) begin
      drive();
      step();
      n++;
    end
    check("emit_reached", 32'(resp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check("rst_resp_chal", 32'(resp_chal), 32'd0);
    step();
    rst_n = 1'b1;
    ready_mode = 0;
    drive();
    step();
    check("rst_no_done", 32'(dut_done - dn0), 32'd0);

    // Randomized sweeps.
    repeat (25) begin
      ready_mode = int'($urandom_range(0, 1));
      resp_mode = 1;
      abort_mode = ($urandom_range(0, 3) == 0) ? 2 : 0;
      f = CHAL_W'($urandom);
      run_sweep(f, CHAL_W'(int'(f) + int'($urandom_range(0, 3))));
      abort_mode = 0;
      repeat ($urandom_range(0, 3)) begin
        drive();
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
